uart_tx_buffered: RTL and testbench

- Buffered 8N1 UART transmitter for the host link: the TPU-side return path toward the PC.
- Upstream logic pushes bytes through a ready/valid port into an internal FIFO.
- The serializer drains the FIFO and drives the tx pin: LSB first, one start bit, STOP_BITS stop bits.
- Consecutive frames go out back-to-back with no idle gap while data is queued.

---
 rtl/uart_tx_buffered.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter for the host return link.
// Bytes enter a small FIFO through a ready/valid port; the serializer drains it
// LSB first with one start bit and STOP_BITS stop bits. Queued frames are sent
// back-to-back without idle cycles.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line high, waiting for a queued byte
// S_START | start bit (low) for one bit period
// S_DATA  | eight data bits, LSB first, one bit period each
// S_STOP  | stop level (high) for STOP_BITS bit periods, then chain or idle
`timescale 1ns/1ps

module uart_tx_buffered #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int          AW           = $clog2(FIFO_DEPTH);
  localparam int          CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam logic [15:0] BIT_RELOAD   = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] FULL_CNT     = (AW + 1)'(FIFO_DEPTH);
  // Any value other than 2 falls back to a single stop bit.
  localparam logic        STOP_TWO     = (STOP_BITS == 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push;
  logic        pop;
  logic [7:0]  head;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        stop_q, stop_d;
  logic        tx_q, tx_d;
  logic        cnt_tc;

  // Occupancy and ready come only from the registered pointers.
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign tx_ready   = (fifo_count != FULL_CNT);
  assign push       = tx_valid && tx_ready;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign cnt_tc     = (cnt_q == 16'd0);

  assign tx      = tx_q;
  assign tx_busy = (state_q != S_IDLE);

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= tx_data;
  end

  // FIFO pointers; reset flushes the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Serializer registers; tx comes straight from a flop and idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic: bit timing is a reload-and-count-down to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (fifo_count != '0) begin
          pop     = 1'b1;
          shift_d = head;
          bit_d   = '0;
          cnt_d   = BIT_RELOAD;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_tc) begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          cnt_d   = BIT_RELOAD;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_tc) begin
          cnt_d = BIT_RELOAD;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            stop_d  = STOP_TWO;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_tc) begin
          if (stop_q) begin
            // First of two stop bits done; run one more period.
            stop_d = 1'b0;
            cnt_d  = BIT_RELOAD;
          end else if (fifo_count != '0) begin
            pop     = 1'b1;
            shift_d = head;
            bit_d   = '0;
            cnt_d   = BIT_RELOAD;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered. Two instances: A (1 stop bit, 16-deep FIFO) and
// B (2 stop bits, 4-deep FIFO), both at 11 clocks per bit.
// The reference model records each accepted byte with its push edge and
// derives its frame start edge as max(push+1, previous start + frame length);
// every cycle's expected tx, busy, count and ready follow from that list.
`timescale 1ns/1ps

module tb_uart_tx_buffered;

  localparam int CF      = 1_000_000;
  localparam int BR      = 90_000;
  localparam int CPB     = CF / BR;
  localparam int DEPTH_A = 16;
  localparam int DEPTH_B = 4;
  localparam int LEN_A   = 10 * CPB;
  localparam int LEN_B   = 11 * CPB;
  localparam int MAXQ    = 512;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, tx_a, busy_a;
  logic       ready_b, tx_b, busy_b;
  logic [4:0] count_a;
  logic [2:0] count_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_buffered #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .FIFO_DEPTH(DEPTH_A), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a),
    .tx(tx_a), .tx_busy(busy_a), .fifo_count(count_a)
  );

  uart_tx_buffered #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .FIFO_DEPTH(DEPTH_B), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b),
    .tx(tx_b), .tx_busy(busy_b), .fifo_count(count_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int         cyc = 0;
  int         push_e  [2][MAXQ];
  int         start_e [2][MAXQ];
  logic [7:0] byte_m  [2][MAXQ];
  int         n_push  [2];

  function automatic int frame_len(input int d);
    return (d == 0) ? LEN_A : LEN_B;
  endfunction

  function automatic int depth(input int d);
    return (d == 0) ? DEPTH_A : DEPTH_B;
  endfunction

  // Bytes accepted by edge t minus bytes whose frame has started by edge t.
  function automatic int m_count(input int d, input int t);
    int c = 0;
    for (int i = 0; i < n_push[d]; i++) begin
      if (push_e[d][i] <= t) c++;
      if (start_e[d][i] <= t) c--;
    end
    return c;
  endfunction

  // Edge counter: after edge number e, cyc == e.
  always @(posedge clk) cyc <= cyc + 1;

  // Model acceptance and frame scheduling.
  always @(posedge clk or negedge rst_n) begin
    int e, s, n;
    logic v;
    logic [7:0] bv;
    if (!rst_n) begin
      n_push[0] <= 0;
      n_push[1] <= 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        v  = (d == 0) ? valid_a : valid_b;
        bv = (d == 0) ? data_a : data_b;
        n  = n_push[d];
        if (v && m_count(d, cyc) != depth(d)) begin
          e = cyc + 1;
          s = e + 1;
          if (n > 0 && start_e[d][n-1] + frame_len(d) > s) s = start_e[d][n-1] + frame_len(d);
          push_e[d][n]  <= e;
          start_e[d][n] <= s;
          byte_m[d][n]  <= bv;
          n_push[d]     <= n + 1;
        end
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int t, k, b, ec;
    logic etx, ebusy;
    logic [7:0] fb;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        t = cyc;
        etx = 1'b1;
        ebusy = 1'b0;
        for (int i = 0; i < n_push[d]; i++) begin
          if (start_e[d][i] <= t && t < start_e[d][i] + frame_len(d)) begin
            k = t - start_e[d][i];
            b = k / CPB;
            fb = byte_m[d][i];
            ebusy = 1'b1;
            etx = (b == 0) ? 1'b0 : (b <= 8) ? fb[b-1] : 1'b1;
          end
        end
        ec = m_count(d, t);
        if (d == 0) begin
          check_val("tx_a", 32'(tx_a), 32'(etx));
          check_val("busy_a", 32'(busy_a), 32'(ebusy));
          check_val("count_a", 32'(count_a), 32'(ec));
          check_val("ready_a", 32'(ready_a), 32'(ec != DEPTH_A));
        end else begin
          check_val("tx_b", 32'(tx_b), 32'(etx));
          check_val("busy_b", 32'(busy_b), 32'(ebusy));
          check_val("count_b", 32'(count_b), 32'(ec));
          check_val("ready_b", 32'(ready_b), 32'(ec != DEPTH_B));
        end
      end
    end
  end

  // Busy-pulse length monitor.
  int   rise_a = 0, rise_b = 0, len_a = 0, len_b = 0;
  logic bprev_a = 1'b0, bprev_b = 1'b0;
  always @(negedge clk) begin
    if (busy_a && !bprev_a) rise_a <= cyc;
    if (!busy_a && bprev_a) len_a <= cyc - rise_a;
    if (busy_b && !bprev_b) rise_b <= cyc;
    if (!busy_b && bprev_b) len_b <= cyc - rise_b;
    bprev_a <= busy_a;
    bprev_b <= busy_b;
  end

  // ---------------- stimulus ----------------
  int max_a = 0;

  task automatic send(input int d, input logic [7:0] b);
    int guard = 0;
    if (d == 0) begin valid_a = 1'b1; data_a = b; end
    else begin valid_b = 1'b1; data_b = b; end
    while (guard < 5000 && !((d == 0) ? ready_a : ready_b)) begin
      @(negedge clk);
      guard++;
      if (int'(count_a) > max_a) max_a = int'(count_a);
    end
    check_val("send_timeout", 32'(guard < 5000), 32'd1);
    @(negedge clk);
    if (int'(count_a) > max_a) max_a = int'(count_a);
  endtask

  task automatic drain(input int d);
    int guard = 0;
    while (guard < 20000 && ((d == 0) ? (busy_a || count_a != 0) : (busy_b || count_b != 0))) begin
      @(negedge clk);
      guard++;
    end
    check_val("drain_timeout", 32'(guard < 20000), 32'd1);
    #1;
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] seq_a5;
    int hi, quiet;
    logic rs_a, rs_b;
    int sent_a, sent_b;

    data_a = '0; data_b = '0; valid_a = 1'b0; valid_b = 1'b0;
    seq_a5 = 10'b1101001010;

    repeat (3) @(negedge clk);
    check_val("rst_tx_a", 32'(tx_a), 32'd1);
    check_val("rst_ready_a", 32'(ready_a), 32'd1);
    check_val("rst_busy_a", 32'(busy_a), 32'd0);
    check_val("rst_count_a", 32'(count_a), 32'd0);
    check_val("rst_tx_b", 32'(tx_b), 32'd1);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte 0xA5: mid-bit samples and busy length.
    send(0, 8'hA5);
    valid_a = 1'b0;
    for (int j = 0; j < LEN_A + 10; j++) begin
      @(negedge clk);
      if (j % CPB == CPB / 2 && j / CPB < 10) check_val("a5_bit", 32'(tx_a), 32'(seq_a5[j / CPB]));
    end
    #1;
    check_val("a5_busy_len", 32'(len_a), 32'(LEN_A));

    // Back-to-back frames.
    send(0, 8'h00);
    send(0, 8'hFF);
    send(0, 8'h55);
    valid_a = 1'b0;
    check_val("b2b_count", 32'(count_a), 32'd2);
    drain(0);
    check_val("b2b_busy_len", 32'(len_a), 32'(3 * LEN_A));

    // Fill the FIFO with 0x00..0x11.
    max_a = 0;
    for (int i = 0; i <= 8'h11; i++) send(0, 8'(i));
    valid_a = 1'b0;
    check_val("full_max_count", 32'(max_a), 32'(DEPTH_A));
    drain(0);
    check_val("full_busy_len", 32'(len_a), 32'(18 * LEN_A));

    // Push on the same edge as the idle pop.
    repeat (3) @(negedge clk);
    send(0, 8'h12);
    send(0, 8'h34);
    valid_a = 1'b0;
    check_val("simul_count", 32'(count_a), 32'd1);
    drain(0);
    check_val("simul_busy_len", 32'(len_a), 32'(2 * LEN_A));

    // Two stop bits on instance B.
    @(negedge clk);
    send(1, 8'h3C);
    valid_b = 1'b0;
    hi = 0;
    for (int j = 0; j < LEN_B + 5; j++) begin
      @(negedge clk);
      if (j >= 9 * CPB && j < 11 * CPB && tx_b) hi++;
    end
    #1;
    check_val("stop2_high", 32'(hi), 32'(2 * CPB));
    check_val("stop2_frame", 32'(len_b), 32'(LEN_B));

    // Reset during bit 3 of 0x81 with four bytes queued.
    @(negedge clk);
    send(0, 8'h81);
    for (int i = 1; i <= 4; i++) send(0, 8'(i));
    valid_a = 1'b0;
    repeat (46) @(negedge clk);
    check_val("pre_rst_tx", 32'(tx_a), 32'd0);
    check_val("pre_rst_count", 32'(count_a), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_tx", 32'(tx_a), 32'd1);
    check_val("mid_rst_count", 32'(count_a), 32'd0);
    check_val("mid_rst_ready", 32'(ready_a), 32'd1);
    check_val("mid_rst_busy", 32'(busy_a), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    quiet = 0;
    for (int j = 0; j < 3 * LEN_A; j++) begin
      @(negedge clk);
      if (!tx_a || busy_a) quiet++;
    end
    check_val("post_rst_quiet", 32'(quiet), 32'd0);

    // Random traffic on both instances.
    rs_a = 1'b0; rs_b = 1'b0; sent_a = 0; sent_b = 0;
    for (int c = 0; c < 3000; c++) begin
      if (valid_a && rs_a) begin valid_a = 1'b0; sent_a++; end
      if (valid_b && rs_b) begin valid_b = 1'b0; sent_b++; end
      if (!valid_a && sent_a < 150 && $urandom_range(0, 3) == 0) begin
        valid_a = 1'b1; data_a = 8'($urandom);
      end
      if (!valid_b && sent_b < 150 && $urandom_range(0, 1) == 0) begin
        valid_b = 1'b1; data_b = 8'($urandom);
      end
      rs_a = ready_a;
      rs_b = ready_b;
      @(negedge clk);
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    drain(0);
    drain(1);
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
